// File: rtl/vram_pkg.sv
// vram_pkg
// Shared types and width constants for the VRAM arbiter slice.
//   slot_owner_t : owner of the current SRAM slot
//   host_cmd_t   : one buffered host command (write flag, address, data)
//   hostOwner()  : maps a host command onto the slot owner that executes it
package vram_pkg;

  localparam int VRAM_ADDR_WIDTH      = 17;
  localparam int VRAM_DATA_WIDTH      = 8;
  localparam int VRAM_HOST_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_VIDEO,
    SLOT_HOST_READ,
    SLOT_HOST_WRITE
  } slot_owner_t;

  typedef struct packed {
    logic                       write;
    logic [VRAM_ADDR_WIDTH-1:0] address;
    logic [VRAM_DATA_WIDTH-1:0] data;
  } host_cmd_t;

  function automatic slot_owner_t hostOwner(input host_cmd_t cmd);
    return cmd.write ? SLOT_HOST_WRITE : SLOT_HOST_READ;
  endfunction

endpackage

// File: rtl/host_cmd_fifo.sv
// host_cmd_fifo
// Small synchronous FIFO holding host commands in arrival order.
// Ports:
//   clock     : system clock
//   reset     : asynchronous, active-low; empties the FIFO
//   i_push    : write i_pushCmd (ignored when full)
//   i_pushCmd : command to store
//   i_pop     : drop the head entry (ignored when empty)
//   o_headCmd : oldest stored command
//   o_count   : number of stored commands
//   o_full    : count == DEPTH
//   o_empty   : count == 0
module host_cmd_fifo
  import vram_pkg::*;
#(
  parameter int DEPTH = VRAM_HOST_FIFO_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_push,
  input  host_cmd_t              i_pushCmd,
  input  logic                   i_pop,
  output host_cmd_t              o_headCmd,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  host_cmd_t          r_entries [DEPTH];
  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [CNT_W-1:0]   r_count;
  logic               w_doPush;
  logic               w_doPop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_headCmd = r_entries[r_rdPtr];

  // A full FIFO refuses pushes even when a pop happens in the same cycle,
  // which keeps the acceptance decision purely on the registered count.
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  // Storage needs no reset: flushing is done by clearing the pointers.
  always_ff @(posedge clock) begin
    if (w_doPush) begin
      r_entries[r_wrPtr] <= i_pushCmd;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter
// Time-multiplexes one external 8-bit SRAM between VGA scanout and a host
// port. The clock runs at twice the pixel rate; every clock edge starts a
// one-cycle slot. Slots started while phase==0 belong to video, slots
// started while phase==1 belong to the host; a video slot with no video
// request is handed to the host instead.
// Ports:
//   clock, reset                       : clock, async active-low reset
//   videoRequest/videoAddress          : scanout fetch request
//   videoData/videoDataReady           : fetched byte + one-cycle strobe
//   hostRequestValid/Ready, hostWrite,
//   hostAddress, hostWriteData         : host command handshake
//   hostReadData/hostReadValid         : host read result + strobe
//   ramAddress, ramDataIn, ramDataOut,
//   ramDataOutEnable, ramOutputEnableN,
//   ramWriteEnableN                    : registered SRAM pins
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_WIDTH      = VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH      = VRAM_DATA_WIDTH,
  parameter int HOST_FIFO_DEPTH = VRAM_HOST_FIFO_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  videoRequest,
  input  logic [ADDR_WIDTH-1:0] videoAddress,
  output logic [DATA_WIDTH-1:0] videoData,
  output logic                  videoDataReady,
  input  logic                  hostRequestValid,
  output logic                  hostRequestReady,
  input  logic                  hostWrite,
  input  logic [ADDR_WIDTH-1:0] hostAddress,
  input  logic [DATA_WIDTH-1:0] hostWriteData,
  output logic [DATA_WIDTH-1:0] hostReadData,
  output logic                  hostReadValid,
  output logic [ADDR_WIDTH-1:0] ramAddress,
  input  logic [DATA_WIDTH-1:0] ramDataIn,
  output logic [DATA_WIDTH-1:0] ramDataOut,
  output logic                  ramDataOutEnable,
  output logic                  ramOutputEnableN,
  output logic                  ramWriteEnableN
);

  localparam int FIFO_COUNT_W = $clog2(HOST_FIFO_DEPTH) + 1;

  // Slot bookkeeping
  logic                    r_phase;
  slot_owner_t             r_owner;
  slot_owner_t             w_nextOwner;

  // SRAM pin registers and their next values
  logic [ADDR_WIDTH-1:0]   r_ramAddress;
  logic [DATA_WIDTH-1:0]   r_ramDataOut;
  logic                    r_ramDataOutEnable;
  logic                    r_ramOutputEnableN;
  logic                    r_ramWriteEnableN;
  logic [ADDR_WIDTH-1:0]   w_nextAddress;
  logic [DATA_WIDTH-1:0]   w_nextDataOut;
  logic                    w_nextDataOutEnable;
  logic                    w_nextOutputEnableN;
  logic                    w_nextWriteEnableN;

  // Response registers
  logic [DATA_WIDTH-1:0]   r_videoData;
  logic                    r_videoDataReady;
  logic [DATA_WIDTH-1:0]   r_hostReadData;
  logic                    r_hostReadValid;

  // Host command FIFO
  host_cmd_t               w_pushCmd;
  host_cmd_t               w_headCmd;
  logic [FIFO_COUNT_W-1:0] w_fifoCount;
  logic                    w_fifoFull;
  logic                    w_fifoEmpty;
  logic                    w_hostPush;
  logic                    w_fifoPop;

  assign w_pushCmd.write   = hostWrite;
  assign w_pushCmd.address = VRAM_ADDR_WIDTH'(hostAddress);
  assign w_pushCmd.data    = VRAM_DATA_WIDTH'(hostWriteData);

  // Ready and full both derive from the registered FIFO count, so gating
  // the push on !full is the same as gating it on ready.
  assign hostRequestReady = (w_fifoCount < FIFO_COUNT_W'(HOST_FIFO_DEPTH));
  assign w_hostPush       = hostRequestValid && !w_fifoFull;

  host_cmd_fifo #(
    .DEPTH(HOST_FIFO_DEPTH)
  ) u_hostFifo (
    .clock     (clock),
    .reset     (reset),
    .i_push    (w_hostPush),
    .i_pushCmd (w_pushCmd),
    .i_pop     (w_fifoPop),
    .o_headCmd (w_headCmd),
    .o_count   (w_fifoCount),
    .o_full    (w_fifoFull),
    .o_empty   (w_fifoEmpty)
  );

  // Owner selection for the slot that starts at the next edge, plus the pin
  // values that slot needs. Pins default to an idle slot with the address
  // and write data held, so a released write leaves no drive behind.
  always_comb begin
    w_nextOwner         = SLOT_IDLE;
    w_fifoPop           = 1'b0;
    w_nextAddress       = r_ramAddress;
    w_nextDataOut       = r_ramDataOut;
    w_nextDataOutEnable = 1'b0;
    w_nextOutputEnableN = 1'b1;
    w_nextWriteEnableN  = 1'b1;

    if (!r_phase && videoRequest) begin
      w_nextOwner = SLOT_VIDEO;
    end else if (!w_fifoEmpty) begin
      w_nextOwner = hostOwner(w_headCmd);
      w_fifoPop   = 1'b1;
    end

    case (w_nextOwner)
      SLOT_VIDEO: begin
        w_nextAddress       = videoAddress;
        w_nextOutputEnableN = 1'b0;
      end
      SLOT_HOST_READ: begin
        w_nextAddress       = ADDR_WIDTH'(w_headCmd.address);
        w_nextOutputEnableN = 1'b0;
      end
      SLOT_HOST_WRITE: begin
        w_nextAddress       = ADDR_WIDTH'(w_headCmd.address);
        w_nextDataOut       = DATA_WIDTH'(w_headCmd.data);
        w_nextDataOutEnable = 1'b1;
        w_nextWriteEnableN  = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // Slot register: phase toggles every clock and the chosen owner and pin
  // values are launched together at the slot start edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_phase            <= 1'b0;
      r_owner            <= SLOT_IDLE;
      r_ramAddress       <= '0;
      r_ramDataOut       <= '0;
      r_ramDataOutEnable <= 1'b0;
      r_ramOutputEnableN <= 1'b1;
      r_ramWriteEnableN  <= 1'b1;
    end else begin
      r_phase            <= ~r_phase;
      r_owner            <= w_nextOwner;
      r_ramAddress       <= w_nextAddress;
      r_ramDataOut       <= w_nextDataOut;
      r_ramDataOutEnable <= w_nextDataOutEnable;
      r_ramOutputEnableN <= w_nextOutputEnableN;
      r_ramWriteEnableN  <= w_nextWriteEnableN;
    end
  end

  // Slot end: a read slot captures the SRAM byte at the edge that closes
  // it and raises its strobe for exactly one cycle. Resetting r_owner
  // discards any read that was in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_videoData      <= '0;
      r_videoDataReady <= 1'b0;
      r_hostReadData   <= '0;
      r_hostReadValid  <= 1'b0;
    end else begin
      r_videoDataReady <= (r_owner == SLOT_VIDEO);
      r_hostReadValid  <= (r_owner == SLOT_HOST_READ);
      if (r_owner == SLOT_VIDEO) begin
        r_videoData <= ramDataIn;
      end
      if (r_owner == SLOT_HOST_READ) begin
        r_hostReadData <= ramDataIn;
      end
    end
  end

  assign ramAddress       = r_ramAddress;
  assign ramDataOut       = r_ramDataOut;
  assign ramDataOutEnable = r_ramDataOutEnable;
  assign ramOutputEnableN = r_ramOutputEnableN;
  assign ramWriteEnableN  = r_ramWriteEnableN;
  assign videoData        = r_videoData;
  assign videoDataReady   = r_videoDataReady;
  assign hostReadData     = r_hostReadData;
  assign hostReadValid    = r_hostReadValid;

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single external 8-bit SRAM between the VGA scanout path and a host read/write port. The main clock runs at twice the pixel rate, so each pixel period is split into two one-clock slots: phase 0 is reserved for the video fetch and phase 1 for the host. An idle video slot (blanking) is donated to the host. Host commands are buffered in a small FIFO, and the block owns all SRAM control-pin timing.

## Interface
Parameters:
- ADDR_WIDTH, 17, SRAM/video address width
- DATA_WIDTH, 8, SRAM data width
- HOST_FIFO_DEPTH, 4, host command FIFO entries; power of two, ≥2

Ports:
- clock  in  1  system clock, 2× pixel rate
- reset  in  1  asynchronous, active-low
- videoRequest  in  1  scanout wants a fetch this pixel; low in blanking
- videoAddress  in  ADDR_WIDTH  fetch address
- videoData  out  DATA_WIDTH  fetched byte
- videoDataReady  out  1  one-cycle strobe; videoData valid
- hostRequestValid  in  1  command offered
- hostRequestReady  out  1  FIFO can accept
- hostWrite  in  1  1 = write, 0 = read
- hostAddress  in  ADDR_WIDTH  command address
- hostWriteData  in  DATA_WIDTH  write byte
- hostReadData  out  DATA_WIDTH  read result
- hostReadValid  out  1  one-cycle strobe; hostReadData valid
- ramAddress  out  ADDR_WIDTH  SRAM address
- ramDataIn  in  DATA_WIDTH  SRAM data pins, input side
- ramDataOut  out  DATA_WIDTH  SRAM data pins, output side
- ramDataOutEnable  out  1  drive ramDataOut onto pins; tri-state buffer lives at top level
- ramOutputEnableN  out  1  SRAM OE#, active-low
- ramWriteEnableN  out  1  SRAM WE#, active-low

## Operation
- `phase` register toggles every clock. It is 0 in the first cycle after reset release.
- **Slot start** (rising edge entering the slot): owner selection and all ram* outputs are registered.
  - Phase 0, videoRequest=1: owner VIDEO.
  - Phase 0, videoRequest=0, FIFO non-empty: owner HOST, with the FIFO head popped.
  - Phase 1, FIFO non-empty: owner HOST, with the FIFO head popped.
  - Otherwise: owner IDLE.
- **Owner states** (ram* outputs during the slot):
  - IDLE: OE#=1, WE#=1, ramDataOutEnable=0; ramAddress holds its last value.
  - VIDEO / HOST read: ramAddress = command address, OE#=0, WE#=1, ramDataOutEnable=0.
  - HOST write: ramAddress = hostAddress, ramDataOut = hostWriteData, ramDataOutEnable=1, WE#=0, OE#=1.
- **Slot end** (next rising edge):
  - Read slots capture ramDataIn into videoData or hostReadData.
  - The matching strobe is high for exactly the following cycle.
  - Writes produce no response.
- Data drive and WE# are released at the same edge that ends the write slot, so a read in the next slot sees OE#=0 with no overlapping drive.
- FIFO:
  - hostRequestReady = (count < HOST_FIFO_DEPTH), from registered count.
  - Push when valid && ready.
  - Push and pop may occur in the same cycle. When full, a same-cycle pop does not allow a push.
  - Commands execute strictly in order. A read after a write to the same address returns the written byte.
- Coherency:
  - A video fetch and a host write to the same address observe memory in slot order.
  - Video slot precedes host slot within a pixel.
- Reset asserted mid-operation:
  - All outputs take their reset values immediately.
  - FIFO is flushed and in-flight reads are discarded (no strobe).
  - phase is cleared to 0.

## Timing
- Reset values:
  - ramAddress=0, ramDataOut=0, ramDataOutEnable=0
  - ramOutputEnableN=1, ramWriteEnableN=1
  - videoData=0, videoDataReady=0
  - hostReadData=0, hostReadValid=0
  - hostRequestReady=1; pushes are ignored while reset is low
- Video latency: videoRequest sampled at the phase-0 slot start; videoDataReady is asserted 2 cycles after that edge.
- Host read latency, FIFO empty:
  - Minimum 2 cycles from the push edge to hostReadValid, when the push lands just before a host-eligible slot.
  - Maximum 3 cycles.
- Sustained host throughput:
  - 1 command per 2 cycles during active video.
  - 1 per cycle in blanking.

## Structure
- Package vram_pkg holds:
  - slot_owner_t enum {SLOT_IDLE, SLOT_VIDEO, SLOT_HOST_READ, SLOT_HOST_WRITE}
  - host_cmd_t struct {write, address, data}
  - width constants
- Sub-module host_cmd_fifo: synchronous FIFO of host_cmd_t, with count, full and empty outputs and the same asynchronous active-low reset.
- The arbiter FSM and the pin registers stay in vram_arbiter.

## Test plan
- Reset release, videoRequest=1 constant, videoAddress=0x00010, RAM model returns 0xA5 → videoDataReady every 2nd cycle, first at cycle 2; videoData=0xA5; OE#=0 only in phase-0 slots.
- Host writes 0x3C to 0x1FFFF, then reads 0x1FFFF, with video active → write slot shows WE#=0 and ramDataOutEnable=1 in phase 1 only; hostReadValid pulses once with 0x3C.
- videoRequest=0 (blanking), push 4 reads to 0x00000..0x00003 back-to-back → four hostReadValid strobes on consecutive cycles, in order.
- Push 5 commands with no pops possible (video active, first command in flight) → hostRequestReady drops after the 4th accept; the 5th is held until a pop, and no command is lost or duplicated.
- Write 0x77 to 0x00100 in the phase-1 slot, video fetch of 0x00100 in the following phase-0 slot → videoData=0x77; WE# and ramDataOutEnable are never asserted during an OE#=0 cycle.
- Assert reset mid host read (after its slot start) → no hostReadValid; all outputs at reset values in the same cycle; FIFO empty after release.
